// File: rtl/popcount_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : popcount_arbiter_if
// Purpose  : Request/response bundle between requesters, consumer and the
//            shared popcount arbiter.
// Revision : 1.0
//==============================================================================
interface popcount_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 5
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [CNT_W-1:0]       rsp_count;
    logic                   rsp_ready;
    logic                   busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/popcount_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : popcount_arbiter
// Purpose  : Shares one 16-bit popcount stage among NREQ requesters, round-robin
//            by default or fixed priority with POPCOUNT_ARB_PRIO_EN defined.
// Revision : 1.0
//==============================================================================
module popcount_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 2,
    parameter int CNT_W  = 5
) (
    input  wire logic            clk,
    input  wire logic            rst,
    popcount_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_word;
    logic [ID_W-1:0]     r_cap_id;
    logic [ID_W-1:0]     r_rsp_id;
    logic [CNT_W-1:0]    r_count;
    logic                r_rsp_valid;

    logic                w_any;
    logic [ID_W-1:0]     w_idx;
    logic [ID_W-1:0]     w_grant_id;
    logic [DATA_W-1:0]   w_grant_data;
    logic [NREQ-1:0]     w_grant_oh;
    logic [CNT_W-1:0]    w_pop;
    logic [DATA_W-1:0]   w_words [NREQ];

`ifndef POPCOUNT_ARB_PRIO_EN
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W:0]       w_sum;
`endif

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_words[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    // Scan candidates starting at the pointer (or at 0 for fixed priority);
    // the first valid one found wins.
    always_comb begin
        w_any        = 1'b0;
        w_idx        = '0;
        w_grant_id   = '0;
        w_grant_data = '0;
        w_grant_oh   = '0;
`ifndef POPCOUNT_ARB_PRIO_EN
        w_sum        = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
`ifdef POPCOUNT_ARB_PRIO_EN
            w_idx = ID_W'(k);
`else
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NREQ)) begin
                w_sum = w_sum - (ID_W+1)'(NREQ);
            end
            w_idx = w_sum[ID_W-1:0];
`endif
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any             = 1'b1;
                w_grant_id        = w_idx;
                w_grant_data      = w_words[w_idx];
                w_grant_oh[w_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int b = 0; b < DATA_W; b++) begin
            w_pop = w_pop + {{(CNT_W-1){1'b0}}, r_word[b]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_cap_id    <= '0;
            r_rsp_id    <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
`ifndef POPCOUNT_ARB_PRIO_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_word   <= w_grant_data;
                        r_cap_id <= w_grant_id;
                        r_state  <= CALC;
                    end
                end
                // Id and count update together so both hold their old values
                // until the new response is ready.
                CALC: begin
                    r_count     <= w_pop;
                    r_rsp_id    <= r_cap_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
`ifndef POPCOUNT_ARB_PRIO_EN
                        r_ptr <= (r_rsp_id == ID_W'(NREQ-1)) ? '0 : r_rsp_id + 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE) ? w_grant_oh : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_count = r_count;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_popcount_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_popcount_arbiter
// Purpose  : Self-checking bench for popcount_arbiter against a queue-free
//            behavioural arbitration/popcount model.
// Revision : 1.0
//==============================================================================
module tb_popcount_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 16;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic rst;

    popcount_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    popcount_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ptr   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration straight from the rules: first valid index found
    // scanning upward from the pointer, or lowest index for fixed priority.
    function automatic int pick(input logic [NREQ-1:0] mask);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
`ifdef POPCOUNT_ARB_PRIO_EN
            idx = k;
`else
            idx = (ptr + k) % NREQ;
`endif
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*DATA_W-1:0] one_word(input int id, input logic [15:0] w);
        logic [NREQ*DATA_W-1:0] v;
        v = '0;
        v[id*DATA_W +: DATA_W] = w;
        return v;
    endfunction

    // Entered and left one time unit after a rising edge.
    task automatic transact(input logic [NREQ-1:0] mask, input logic [NREQ*DATA_W-1:0] words,
                            input int hold);
        int g;
        logic [15:0] w;
        int cnt;
        bus.req_valid = mask;
        bus.req_data  = words;
        bus.rsp_ready = 1'b0;
        g   = pick(mask);
        w   = words[g*DATA_W +: DATA_W];
        cnt = $countones(w);
        @(negedge clk);
        check("grant", 32'(bus.req_ready), 32'(1) << g);
        check("idle_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("calc_ready", 32'(bus.req_ready), 32'd0);
        check("calc_busy", 32'(bus.busy), 32'd1);
        check("calc_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_id", 32'(bus.rsp_id), 32'(g));
            check("hold_count", 32'(bus.rsp_count), 32'(cnt));
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_id", 32'(bus.rsp_id), 32'(g));
        check("rsp_count", 32'(bus.rsp_count), 32'(cnt));
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        ptr = (g + 1) % NREQ;
        check("post_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_id", 32'(bus.rsp_id), 32'(g));
        check("post_count", 32'(bus.rsp_count), 32'(cnt));
        check("post_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        bus.req_valid = '0;
        repeat (n) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.req_ready), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [NREQ*DATA_W-1:0] words;
        logic [NREQ-1:0]        mask;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_id", 32'(bus.rsp_id), 32'd0);
        check("rst_count", 32'(bus.rsp_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;

        transact(4'b0001, one_word(0, 16'hFFFF), 0);

        transact(4'b0010, one_word(1, 16'h0000), 0);
        transact(4'b0100, one_word(2, 16'h8001), 0);
        transact(4'b1000, one_word(3, 16'h7FFF), 0);
        transact(4'b0001, one_word(0, 16'hAAAA), 0);
        idle_cycles(2);

        // All requesters valid at once, back to back with rsp_ready high.
        words = {16'hAAAA, 16'h00FF, 16'h0001, 16'h0000};
        repeat (5) transact(4'b1111, words, 0);
        idle_cycles(1);

        words = {$urandom, $urandom};
        transact(4'b1000, words, 0);
        transact(4'b1010, words, 0);
        transact(4'b1010, words, 0);

        transact(4'b0101, {$urandom, $urandom}, 5);
        idle_cycles(1);

        for (int it = 0; it < 40; it++) begin
            mask  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            words = {$urandom, $urandom};
            if (it % 7 == 0) words[15:0] = 16'hFFFF;
            transact(mask, words, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end

        // Asynchronous reset while a response is pending.
        bus.req_valid = 4'b0100;
        bus.req_data  = one_word(2, 16'h1234);
        bus.rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        #2 rst = 1'b1;
        bus.req_valid = '0;
        #1;
        check("arst_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_id", 32'(bus.rsp_id), 32'd0);
        check("arst_count", 32'(bus.rsp_count), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        ptr = 0;
        idle_cycles(2);
        transact(4'b1111, {$urandom, $urandom}, 0);
        transact(4'b1111, {$urandom, $urandom}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
